// File: rtl/dacq_scan_sequencer_if.sv
// Signal bundle between the scan sequencer, the acquisition core and the CPU-side record reader.
interface dacq_scan_sequencer_if;
   logic        Start;
   logic        Abort;
   logic [7:0]  ScanMask;
   logic [1:0]  Mode;
   logic [23:0] BaseCommand;
   logic [15:0] TimeoutLimit;
   logic [2:0]  StatusBits;
   logic [31:0] ResultForCPU;
   logic [31:0] CPUCommand;
   logic        STATUS_CLEAR;
   logic        CoreEn;
   logic        FifoRdEn;
   logic [31:0] FifoRdData;
   logic [3:0]  FifoCount;
   logic        FifoEmpty;
   logic        FifoFull;
   logic        ScanBusy;
   logic        ScanDone;
   logic        Overflow;

   modport slave (
      input  Start, Abort, ScanMask, Mode, BaseCommand, TimeoutLimit, StatusBits, ResultForCPU, FifoRdEn,
      output CPUCommand, STATUS_CLEAR, CoreEn, FifoRdData, FifoCount, FifoEmpty, FifoFull,
             ScanBusy, ScanDone, Overflow
   );

   modport master (
      output Start, Abort, ScanMask, Mode, BaseCommand, TimeoutLimit, StatusBits, ResultForCPU, FifoRdEn,
      input  CPUCommand, STATUS_CLEAR, CoreEn, FifoRdData, FifoCount, FifoEmpty, FifoFull,
             ScanBusy, ScanDone, Overflow
   );
endinterface

// File: rtl/dacq_scan_sequencer.sv
// Walks the enabled sensor selects, issues one command per sensor to the acquisition core,
// and queues result or timeout records in an 8-deep show-ahead FIFO for the CPU.
module dacq_scan_sequencer (
   input  logic                  Clk,
   input  logic                  Rst,
   dacq_scan_sequencer_if.slave  bus
);
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned PTR_W      = 3;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned WD_W       = 16;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned BASE_W     = 22;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_CLEAR, S_SETTLE, S_RECOVER
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [BASE_W-1:0]   base_q, base_d;
   logic [7:0]          mask_q, mask_d;
   logic [2:0]          psel_q, psel_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic                aborted_q, aborted_d;
   logic [WORD_W-1:0]   cmd_q, cmd_d;
   logic                clear_q, clear_d;
   logic                core_en_q, core_en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_set_c;
   logic [CNT_W-1:0]    count_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
   logic                push_c, pop_c;
   logic [WORD_W-1:0]   push_data_c;
   logic                fifo_full_c, fifo_empty_c;
   logic                mode_ok_c, start_ok_c, abort_take_c, timeout_c;
   logic [3:0]          first_sel_c, next_sel_c;
   logic                unused_bits;

   // Lowest enabled select strictly above cur; bit 3 of the result flags "found".
   function automatic logic [3:0] find_sel(input logic [7:0] mask, input logic [2:0] cur);
      logic [3:0] sel;
      sel = 4'b0000;
      for (int i = 7; i >= 1; i--) begin
         if (mask[3'(i)] && (3'(i) > cur)) sel = {1'b1, 3'(i)};
      end
      return sel;
   endfunction

   assign fifo_full_c  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty_c = (count_q == '0);
   assign pop_c        = bus.FifoRdEn && !fifo_empty_c;
   assign mode_ok_c    = (bus.Mode == 2'b01) || (bus.Mode == 2'b10);
   assign start_ok_c   = bus.Start && mode_ok_c && (bus.ScanMask[7:1] != 7'd0);
   assign abort_take_c = bus.Abort && (state_q != S_IDLE) && (state_q != S_RECOVER);
   assign timeout_c    = (bus.TimeoutLimit != '0) && (wd_q == bus.TimeoutLimit);
   assign first_sel_c  = find_sel(bus.ScanMask, 3'd0);
   assign next_sel_c   = find_sel(mask_q, psel_q);
   assign unused_bits  = ^{bus.StatusBits[2:1], bus.BaseCommand[1:0], bus.ResultForCPU[12:0]};

   always_ff @(posedge Clk) begin
      if (Rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort_take_c) begin
         state_d = S_RECOVER;
      end else begin
         case (state_q)
            S_IDLE:    if (start_ok_c) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (bus.StatusBits[0]) state_d = S_CAPTURE;
                       else if (timeout_c)    state_d = S_RECOVER;
            S_CAPTURE: if (!fifo_full_c) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_SETTLE;
            S_SETTLE:  state_d = next_sel_c[3] ? S_ISSUE : S_IDLE;
            S_RECOVER: state_d = (aborted_q || bus.Abort || !next_sel_c[3]) ? S_IDLE : S_ISSUE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are computed from the next state so the registered copies line up with state_q.
   always_comb begin
      cmd_d       = '0;
      ovf_set_c   = 1'b0;
      push_c      = 1'b0;
      push_data_c = '0;
      done_d      = 1'b0;
      mode_d      = mode_q;
      base_d      = base_q;
      mask_d      = mask_q;
      psel_d      = psel_q;
      wd_d        = wd_q;
      aborted_d   = aborted_q || abort_take_c;
      case (state_q)
         S_IDLE: begin
            aborted_d = 1'b0;
            if (start_ok_c) begin
               mode_d = bus.Mode;
               base_d = bus.BaseCommand[23:2];
               mask_d = bus.ScanMask;
               psel_d = first_sel_c[2:0];
            end else if (bus.Start && mode_ok_c) begin
               done_d = 1'b1;
            end
         end
         S_ISSUE: wd_d = '0;
         S_WAIT: begin
            if (!bus.StatusBits[0]) begin
               wd_d = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);
               if (timeout_c && !abort_take_c) begin
                  if (fifo_full_c) begin
                     ovf_set_c = 1'b1;
                  end else begin
                     push_c      = 1'b1;
                     push_data_c = {16'h0000, 3'b111, psel_q, 8'h00, 2'b11};
                  end
               end
            end
         end
         S_CAPTURE: begin
            if (!fifo_full_c && !abort_take_c) begin
               push_c      = 1'b1;
               push_data_c = {bus.ResultForCPU[31:13], psel_q, 8'h00, 2'b01};
            end
         end
         S_SETTLE, S_RECOVER: begin
            if (state_d == S_ISSUE) psel_d = next_sel_c[2:0];
            done_d = (state_d == S_IDLE) && !aborted_q && !bus.Abort;
         end
         default: ;
      endcase
      if (state_d == S_ISSUE) cmd_d = {mode_d, psel_d, 3'b000, base_d, 2'b00};
      clear_d   = (state_d == S_CLEAR) || (state_d == S_RECOVER);
      core_en_d = (state_d != S_RECOVER);
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cmd_q     <= '0;
         clear_q   <= 1'b0;
         core_en_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         mode_q    <= '0;
         base_q    <= '0;
         mask_q    <= '0;
         psel_q    <= '0;
         wd_q      <= '0;
         aborted_q <= 1'b0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         cmd_q     <= cmd_d;
         clear_q   <= clear_d;
         core_en_q <= core_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_q || ovf_set_c;
         mode_q    <= mode_d;
         base_q    <= base_d;
         mask_q    <= mask_d;
         psel_q    <= psel_d;
         wd_q      <= wd_d;
         aborted_q <= aborted_d;
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push_c && !pop_c)      count_q <= count_q + CNT_W'(1);
         else if (!push_c && pop_c) count_q <= count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (push_c) mem_q[wr_ptr_q] <= push_data_c;
   end

   assign bus.CPUCommand   = cmd_q;
   assign bus.STATUS_CLEAR = clear_q;
   assign bus.CoreEn       = core_en_q;
   assign bus.ScanBusy     = busy_q;
   assign bus.ScanDone     = done_q;
   assign bus.Overflow     = ovf_q;
   assign bus.FifoCount    = count_q;
   assign bus.FifoEmpty    = fifo_empty_c;
   assign bus.FifoFull     = fifo_full_c;
   assign bus.FifoRdData   = fifo_empty_c ? '0 : mem_q[rd_ptr_q];
endmodule

// File: tb/tb_dacq_scan_sequencer.sv
// Directed bench for dacq_scan_sequencer: table of full scans plus hand sequences for
// abort, FIFO-full stall, overflow, invalid starts and mid-scan reset.
module tb_dacq_scan_sequencer;
   logic Clk = 1'b0;
   logic Rst;

   dacq_scan_sequencer_if bus ();

   dacq_scan_sequencer dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0]  mask;
      logic [1:0]  mode;
      logic [23:0] base;
      logic [15:0] tlim;
      int          delay;
      logic [31:0] result;
      int          n_rec;
      logic [31:0] rec0, rec1, rec2;
      int          n_iss;
      logic [31:0] cmd0, cmd1, cmd2;
      int          n_clr;
      int          n_low;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   int          n_issue, n_clear, n_low, n_done;
   logic [31:0] cmd_log [8];
   bit          core_pending;
   int          core_wait;
   int          core_delay = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      n_issue = 0; n_clear = 0; n_low = 0; n_done = 0;
      core_pending = 1'b0;
      for (int i = 0; i < 8; i++) cmd_log[i] = '0;
   endtask

   // One clock: observe registered outputs at the falling edge and play the core's part.
   task automatic tick();
      @(negedge Clk);
      if (bus.CPUCommand != 32'h0) begin
         if (n_issue < 8) cmd_log[n_issue] = bus.CPUCommand;
         n_issue++;
         core_pending = 1'b1;
         core_wait    = core_delay;
      end
      if (bus.STATUS_CLEAR) begin n_clear++; core_pending = 1'b0; end
      if (!bus.CoreEn)      begin n_low++;   core_pending = 1'b0; end
      if (bus.ScanDone) n_done++;
      if (core_pending && core_delay >= 0 && core_wait == 0) begin
         bus.StatusBits = 3'b001;
      end else begin
         bus.StatusBits = 3'b000;
         if (core_pending && core_wait > 0) core_wait--;
      end
   endtask

   task automatic start_scan(input logic [7:0] mask, input logic [1:0] mode, input logic [23:0] base,
                             input logic [15:0] tlim, input int delay);
      bus.ScanMask = mask; bus.Mode = mode; bus.BaseCommand = base;
      bus.TimeoutLimit = tlim; core_delay = delay;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while (n_done == 0 && cyc < 400) begin
         tick();
         cyc++;
      end
      chk({name, " scan_done"}, 32'(n_done), 32'd1);
   endtask

   task automatic pop_check(input string name, input logic [31:0] exp);
      chk(name, bus.FifoRdData, exp);
      bus.FifoRdEn = 1'b1;
      tick();
      bus.FifoRdEn = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      vec_t        vecs [4];
      logic [31:0] er [3];
      logic [31:0] ec [3];

      // {mask, mode, base, tlim, delay(-1 never), result, n_rec, rec0..2, n_iss, cmd0..2, clears, coreen_low}
      vecs[0] = '{8'h06, 2'b10, 24'hABCDEF, 16'd0, 5, 32'h1234_F0F0,
                  2, 32'h1234E401, 32'h1234E801, 32'h0,
                  2, 32'h88ABCDEC, 32'h90ABCDEC, 32'h0, 2, 0};
      vecs[1] = '{8'h10, 2'b01, 24'h000003, 16'd4, -1, 32'hCAFE_BABE,
                  1, 32'h0000F003, 32'h0, 32'h0,
                  1, 32'h60000000, 32'h0, 32'h0, 1, 1};
      vecs[2] = '{8'hA2, 2'b01, 24'h000100, 16'd0, 1, 32'hDEAD_2000,
                  3, 32'hDEAD2401, 32'hDEAD3401, 32'hDEAD3C01,
                  3, 32'h48000100, 32'h68000100, 32'h78000100, 3, 0};
      vecs[3] = '{8'h81, 2'b10, 24'hFFFFFF, 16'd0, 0, 32'hFFFF_FFFF,
                  1, 32'hFFFFFC01, 32'h0, 32'h0,
                  1, 32'hB8FFFFFC, 32'h0, 32'h0, 1, 0};

      bus.Start = 1'b0; bus.Abort = 1'b0; bus.ScanMask = '0; bus.Mode = '0;
      bus.BaseCommand = '0; bus.TimeoutLimit = '0; bus.StatusBits = '0;
      bus.ResultForCPU = '0; bus.FifoRdEn = 1'b0;
      Rst = 1'b1;
      clear_counts();
      repeat (3) tick();
      Rst = 1'b0;
      tick();

      chk("rst cpu_command", bus.CPUCommand, 32'h0);
      chk("rst status_clear", 32'(bus.STATUS_CLEAR), 32'd0);
      chk("rst core_en", 32'(bus.CoreEn), 32'd1);
      chk("rst scan_busy", 32'(bus.ScanBusy), 32'd0);
      chk("rst fifo_empty", 32'(bus.FifoEmpty), 32'd1);
      chk("rst fifo_count", 32'(bus.FifoCount), 32'd0);
      chk("rst rd_data", bus.FifoRdData, 32'h0);

      for (int v = 0; v < 4; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         er[0] = vecs[v].rec0; er[1] = vecs[v].rec1; er[2] = vecs[v].rec2;
         ec[0] = vecs[v].cmd0; ec[1] = vecs[v].cmd1; ec[2] = vecs[v].cmd2;
         clear_counts();
         bus.ResultForCPU = vecs[v].result;
         start_scan(vecs[v].mask, vecs[v].mode, vecs[v].base, vecs[v].tlim, vecs[v].delay);
         wait_done(tag);
         chk({tag, " busy_after"}, 32'(bus.ScanBusy), 32'd0);
         chk({tag, " issues"}, 32'(n_issue), 32'(vecs[v].n_iss));
         chk({tag, " clears"}, 32'(n_clear), 32'(vecs[v].n_clr));
         chk({tag, " core_en_low"}, 32'(n_low), 32'(vecs[v].n_low));
         chk({tag, " count"}, 32'(bus.FifoCount), 32'(vecs[v].n_rec));
         for (int j = 0; j < vecs[v].n_iss; j++)
            chk($sformatf("%s cmd%0d", tag, j), cmd_log[j], ec[j]);
         for (int j = 0; j < vecs[v].n_rec; j++)
            pop_check($sformatf("%s rec%0d", tag, j), er[j]);
         chk({tag, " empty_after"}, 32'(bus.FifoEmpty), 32'd1);
         chk({tag, " rd_data_empty"}, bus.FifoRdData, 32'h0);
         chk({tag, " overflow"}, 32'(bus.Overflow), 32'd0);
      end

      // Invalid mode: nothing happens.
      clear_counts();
      start_scan(8'h06, 2'b11, 24'h0, 16'd0, 0);
      repeat (3) tick();
      chk("mode11 issues", 32'(n_issue), 32'd0);
      chk("mode11 busy", 32'(bus.ScanBusy), 32'd0);
      chk("mode11 done", 32'(n_done), 32'd0);

      // Only bit 0 in the mask: done pulse, no scan.
      clear_counts();
      start_scan(8'h01, 2'b01, 24'h0, 16'd0, 0);
      chk("mask01 done_pulse", 32'(bus.ScanDone), 32'd1);
      chk("mask01 busy", 32'(bus.ScanBusy), 32'd0);
      tick();
      chk("mask01 done_drop", 32'(bus.ScanDone), 32'd0);
      chk("mask01 issues", 32'(n_issue), 32'd0);

      // One record left in the FIFO, then abort a scan in WAIT.
      clear_counts();
      bus.ResultForCPU = 32'h0BAD_6000;
      start_scan(8'h02, 2'b01, 24'h0, 16'd0, 0);
      wait_done("prep");
      clear_counts();
      start_scan(8'h04, 2'b01, 24'h0, 16'd0, -1);
      repeat (3) tick();
      chk("abort busy_before", 32'(bus.ScanBusy), 32'd1);
      bus.Abort = 1'b1;
      tick();
      bus.Abort = 1'b0;
      repeat (5) tick();
      chk("abort core_en_low", 32'(n_low), 32'd1);
      chk("abort no_done", 32'(n_done), 32'd0);
      chk("abort idle", 32'(bus.ScanBusy), 32'd0);
      chk("abort count", 32'(bus.FifoCount), 32'd1);

      // Fill to 8 records.
      clear_counts();
      bus.ResultForCPU = 32'h5555_A000;
      start_scan(8'hFE, 2'b10, 24'h0, 16'd0, 2);
      wait_done("fill");
      chk("fill count", 32'(bus.FifoCount), 32'd8);
      chk("fill full", 32'(bus.FifoFull), 32'd1);

      // A ninth result must stall in CAPTURE until one pop frees a slot.
      clear_counts();
      bus.ResultForCPU = 32'h7777_E000;
      start_scan(8'h08, 2'b01, 24'h0, 16'd0, 1);
      repeat (12) tick();
      chk("stall busy", 32'(bus.ScanBusy), 32'd1);
      chk("stall no_clear", 32'(n_clear), 32'd0);
      chk("stall no_done", 32'(n_done), 32'd0);
      chk("stall count", 32'(bus.FifoCount), 32'd8);
      pop_check("stall pop_head", 32'h0BAD6401);
      wait_done("stall");
      chk("stall count_after", 32'(bus.FifoCount), 32'd8);
      chk("stall clears", 32'(n_clear), 32'd1);
      chk("stall overflow", 32'(bus.Overflow), 32'd0);

      // Timeout while full: record dropped, Overflow sticky.
      clear_counts();
      start_scan(8'h02, 2'b01, 24'h0, 16'd2, -1);
      wait_done("ovf");
      chk("ovf flag", 32'(bus.Overflow), 32'd1);
      chk("ovf count", 32'(bus.FifoCount), 32'd8);
      chk("ovf core_en_low", 32'(n_low), 32'd1);

      pop_check("drain rec0", 32'h5555A401);
      pop_check("drain rec1", 32'h5555A801);
      pop_check("drain rec2", 32'h5555AC01);
      pop_check("drain rec3", 32'h5555B001);
      chk("drain count", 32'(bus.FifoCount), 32'd4);
      chk("drain overflow_sticky", 32'(bus.Overflow), 32'd1);

      // Reset in the middle of WAIT.
      clear_counts();
      start_scan(8'h02, 2'b01, 24'h0, 16'd0, -1);
      repeat (3) tick();
      chk("midrst busy_before", 32'(bus.ScanBusy), 32'd1);
      Rst = 1'b1;
      tick();
      chk("midrst cpu_command", bus.CPUCommand, 32'h0);
      chk("midrst status_clear", 32'(bus.STATUS_CLEAR), 32'd0);
      chk("midrst core_en", 32'(bus.CoreEn), 32'd1);
      chk("midrst busy", 32'(bus.ScanBusy), 32'd0);
      chk("midrst done", 32'(bus.ScanDone), 32'd0);
      chk("midrst overflow", 32'(bus.Overflow), 32'd0);
      chk("midrst count", 32'(bus.FifoCount), 32'd0);
      chk("midrst empty", 32'(bus.FifoEmpty), 32'd1);
      chk("midrst full", 32'(bus.FifoFull), 32'd0);
      chk("midrst rd_data", bus.FifoRdData, 32'h0);
      Rst = 1'b0;
      repeat (3) tick();
      chk("midrst no_pulses", 32'(n_low + n_clear + n_done), 32'd0);
      chk("midrst stays_idle", 32'(bus.ScanBusy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dacq_scan_sequencer.md
DACQ_SCAN_SEQUENCER -- requirements
Module: dacq_scan_sequencer

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset; all ports listed below:
REQ-002 Clk  in  1  rising-edge clock, shared with the acquisition core.
REQ-003 Rst  in  1  synchronous active-high reset.
REQ-004 Start  in  1  single-cycle pulse; begins a scan when IDLE.
REQ-005 Abort  in  1  terminates the scan from any state.
REQ-006 ScanMask  in  8  bit n=1 enables PSELx n; bit 0 ignored.
REQ-007 Mode  in  2  command mode; 01 fast, 10 slow.
REQ-008 BaseCommand  in  24  command bits [23:0]; bits [1:0] ignored.
REQ-009 TimeoutLimit  in  16  watchdog limit in cycles; 0 disables the watchdog.
REQ-010 StatusBits  in  3  core status {busy, err_sticky, done}.
REQ-011 ResultForCPU  in  32  core result word.
REQ-012 CPUCommand  out  32  command word to the core.
REQ-013 STATUS_CLEAR  out  1  clear pulse to the core.
REQ-014 CoreEn  out  1  core enable; driven low to recover the core.
REQ-015 FifoRdEn  in  1  pops the head record.
REQ-016 FifoRdData  out  32  head record (show-ahead).
REQ-017 FifoCount  out  4  occupancy, 0..8.
REQ-018 FifoEmpty / FifoFull  out  1 each  occupancy flags.
REQ-019 ScanBusy  out  1  high in every state except IDLE.
REQ-020 ScanDone  out  1  one-cycle pulse at scan end.
REQ-021 Overflow  out  1  sticky flag; cleared only by Rst.

Function
REQ-022 States: IDLE, ISSUE, WAIT, CAPTURE, CLEAR, SETTLE, RECOVER; every output is registered except FifoRdData, FifoEmpty, FifoFull.
REQ-023 IDLE: Start=1 with Mode in {01,10} and a nonzero mask[7:1] -> latch Mode, BaseCommand and the mask, select the lowest enabled PSELx, go to ISSUE.
REQ-024 IDLE: Start with Mode 00 or 11 -> ignored; Start with mask[7:1]=0 -> ScanDone pulses next cycle, stay IDLE; Start while not IDLE is ignored.
REQ-025 ISSUE, exactly 1 cycle: CPUCommand = {Mode, PSELx[2:0], 3'b000, BaseCommand[23:2], 2'b00}; clear watchdog counter; go to WAIT.
REQ-026 CPUCommand SHALL be 0 in every state other than ISSUE, so the core never re-triggers.
REQ-027 WAIT: StatusBits[0]=1 -> CAPTURE; else the counter increments; counter == TimeoutLimit (nonzero) -> push a timeout record, go to RECOVER.
REQ-028 CAPTURE: if not FifoFull, push {ResultForCPU[31:16], ResultForCPU[15:13], PSELx, 8'b0, 1'b0, 1'b1} and go to CLEAR; if full, stall in CAPTURE.
REQ-029 Timeout record = {16'h0000, 3'b111, PSELx, 8'b0, 1'b1, 1'b1}; if FifoFull at timeout, drop it and set Overflow.
REQ-030 CLEAR, 1 cycle: STATUS_CLEAR=1; go to SETTLE.
REQ-031 SETTLE, 1 cycle: advance to the next higher enabled PSELx -> ISSUE; if none remain -> ScanDone pulse, go to IDLE.
REQ-032 RECOVER, 1 cycle: CoreEn=0 and STATUS_CLEAR=1; then continue as in SETTLE.
REQ-033 Abort (priority over all transitions except Rst): go to RECOVER, then IDLE with no ScanDone; FIFO contents are retained.
REQ-034 FIFO: depth 8, in write order; FifoRdData = head record, or 0 when empty.
REQ-035 FifoRdEn when empty is ignored.
REQ-036 Simultaneous push and pop: both occur and the count is unchanged.
REQ-037 A push is allowed only if not full before the pop; there is no bypass when full.
REQ-038 Watchdog counter: 16 bits, saturates, never wraps.

Reset
REQ-039 Rst=1 at a clock edge: state IDLE; CPUCommand=0; STATUS_CLEAR=0; CoreEn=1; ScanBusy=0; ScanDone=0; Overflow=0; FIFO emptied (FifoCount=0, FifoEmpty=1, FifoFull=0, FifoRdData=0).
REQ-040 Rst mid-scan SHALL abandon the scan with no ScanDone and no pulse on CoreEn or STATUS_CLEAR.

Verification
REQ-041 Mask 8'h06, Mode 10, core done after 5 cycles per sensor -> records for PSELx 1 then 2 with bit0=1 and bit1=0, 2 STATUS_CLEAR pulses, 1 ScanDone, CPUCommand[29:27]=1 then 2.
REQ-042 Mask 8'h10, TimeoutLimit 4, core never done -> one record 0x0000F003|(4<<10), CoreEn low for 1 cycle, ScanDone.
REQ-043 FIFO holds 8 records, scan finishes a 9th with no pops -> stall in CAPTURE with STATUS_CLEAR=0; one pop -> the record is pushed, count stays 8.
REQ-044 Abort during WAIT -> CoreEn low for 1 cycle, IDLE, no ScanDone, FifoCount unchanged.
REQ-045 Start with Mode 11 -> no state change, CPUCommand stays 0; Start with mask 8'h01 -> ScanDone only.
REQ-046 Rst asserted mid-WAIT -> all REQ-039 values on the next cycle.
